// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory access path: op codes, controller
// states and the data segment base address.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } mau_state_e;

  localparam logic [31:0] DATA_BASE = 32'h1000_0000;

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends load data, and merges a
// byte/half store into the word read back from memory.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic        [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    unique case (op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h0, byte_sel};
      OP_LH:   load_data = 32'(half_sel);
      OP_LHU:  load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase

    store_word = wdata;
    if (op == OP_SB) begin
      store_word = rdata;
      store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
    end else if (op == OP_SH) begin
      store_word = rdata;
      if (addr_lo[1]) store_word[31:16] = wdata[15:0];
      else            store_word[15:0]  = wdata[15:0];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller in front of a word-only DMEM: range/alignment checks,
// sub-word loads with extension, and read-modify-write for SB/SH.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int          READ_WAIT = 2,
  parameter logic [31:0] BASE_ADDR = DATA_BASE,
  parameter int          NUM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_fault,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  localparam logic [31:0] LAST_BYTE = BASE_ADDR + 32'(4 * NUM_WORDS) - 32'd1;
  localparam int          CNT_W     = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  mau_state_e       state, state_nxt;
  mem_op_e          op_q;
  logic [1:0]       lane_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept, fault_acc, wait_done;
  logic [31:0]      load_val, store_word;

  function automatic logic access_fault(input mem_op_e op, input logic [31:0] addr);
    logic range_bad, align_bad;
    range_bad = addr[31] || (addr < BASE_ADDR) || (addr > LAST_BYTE);
    case (op)
      OP_LH, OP_LHU, OP_SH: align_bad = addr[0];
      OP_LW, OP_SW:         align_bad = |addr[1:0];
      default:              align_bad = 1'b0;
    endcase
    return range_bad || align_bad;
  endfunction

  assign accept     = req_valid && (state == IDLE);
  assign fault_acc  = access_fault(mem_op_e'(req_op), req_addr);
  assign wait_done  = (wait_cnt == CNT_W'(READ_WAIT - 1));

  // Handshake and DMEM strobes decode straight from the state register so
  // that an asynchronous reset removes them immediately.
  assign req_ready  = (state == IDLE);
  assign dmem_read  = (state == RD_WAIT);
  assign dmem_write = (state == WR);
  assign resp_valid = (state == RESP);

  mem_lane_align u_align (
    .op         (op_q),
    .addr_lo    (lane_q),
    .rdata      (dmem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_val),
    .store_word (store_word)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (fault_acc)                       state_nxt = RESP;
          else if (mem_op_e'(req_op) == OP_SW) state_nxt = WR;
          else                                 state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: if (wait_done) state_nxt = is_store(op_q) ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture: only meaningful while a request is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= mem_op_e'(req_op);
      lane_q  <= req_addr[1:0];
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      dmem_address <= '0;
      dmem_wdata   <= '0;
      resp_data    <= '0;
      resp_fault   <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (accept) begin
            wait_cnt <= '0;
            if (fault_acc) begin
              resp_fault <= 1'b1;
              resp_data  <= '0;
            end else begin
              dmem_address <= {req_addr[31:2], 2'b00};
              dmem_wdata   <= req_wdata;
            end
          end
        end
        RD_WAIT: begin
          if (wait_done) begin
            if (is_store(op_q)) begin
              dmem_wdata <= store_word;
            end else begin
              resp_data  <= load_val;
              resp_fault <= 1'b0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WR: begin
          resp_data  <= '0;
          resp_fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 32-word DMEM.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  localparam int RW = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = 5'd0;
  logic [31:0] pl_val = 32'h0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          lat;
    int          reads;
    int          writes;
  } exp_t;
  exp_t sbq[$];

  mem_access_unit #(.READ_WAIT(RW), .BASE_ADDR(32'h1000_0000), .NUM_WORDS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_fault   (resp_fault),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata)
  );

  always #5 clk = ~clk;

  assign dmem_rdata = mem[dmem_address[6:2]];

  always @(posedge clk) begin
    if (dmem_write)  mem[dmem_address[6:2]] <= dmem_wdata;
    else if (pl_en)  mem[pl_idx] <= pl_val;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pl_idx = 5'(idx); pl_val = val; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Reference behaviour of one request; updates the reference memory for stores.
  task automatic model(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, output exp_t e);
    logic [31:0] w, m;
    logic [4:0]  idx;
    logic [7:0]  b;
    logic [15:0] h;
    logic        bad;
    int          sh;
    idx = addr[6:2];
    w   = ref_mem[idx];
    sh  = 8 * int'(addr[1:0]);
    b   = 8'(w >> sh);
    h   = addr[1] ? w[31:16] : w[15:0];
    bad = addr[31] || (addr < 32'h1000_0000) || (addr > 32'h1000_007F);
    if ((op == 3'd1 || op == 3'd4 || op == 3'd6) && addr[0]) bad = 1'b1;
    if ((op == 3'd2 || op == 3'd7) && (addr[1:0] != 2'b00)) bad = 1'b1;
    e.data = 32'h0; e.fault = 1'b0; e.lat = RW + 1; e.reads = RW; e.writes = 0;
    if (bad) begin
      e.fault = 1'b1; e.lat = 1; e.reads = 0;
    end else begin
      case (op)
        3'd0: e.data = {{24{b[7]}}, b};
        3'd1: e.data = {{16{h[15]}}, h};
        3'd2: e.data = w;
        3'd3: e.data = {24'h0, b};
        3'd4: e.data = {16'h0, h};
        3'd5: begin
          m = 32'hFF << sh;
          ref_mem[idx] = (w & ~m) | ((32'(wd[7:0]) << sh) & m);
          e.lat = RW + 2; e.writes = 1;
        end
        3'd6: begin
          ref_mem[idx] = addr[1] ? {wd[15:0], w[15:0]} : {w[31:16], wd[15:0]};
          e.lat = RW + 2; e.writes = 1;
        end
        default: begin
          ref_mem[idx] = wd;
          e.lat = 2; e.reads = 0; e.writes = 1;
        end
      endcase
    end
  endtask

  task automatic issue(input string tag, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t e, g;
    int   lat, rd, wr, guard;
    logic busy_rdy, clash;
    guard = 0;
    while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    model(op, addr, wd, e);
    sbq.push_back(e);
    req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; rd = 0; wr = 0; busy_rdy = 1'b0; clash = 1'b0;
    while (!resp_valid && lat < 50) begin
      if (dmem_read)  rd++;
      if (dmem_write) wr++;
      if (req_ready)  busy_rdy = 1'b1;
      if (dmem_read && dmem_write) clash = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    g = sbq.pop_front();
    chk({tag, "_lat"},    32'(lat), 32'(g.lat));
    chk({tag, "_data"},   resp_data, g.data);
    chk({tag, "_fault"},  32'(resp_fault), 32'(g.fault));
    chk({tag, "_reads"},  32'(rd), 32'(g.reads));
    chk({tag, "_writes"}, 32'(wr), 32'(g.writes));
    chk({tag, "_busy"},   32'({busy_rdy, req_ready, clash}), 32'h0);
  endtask

  initial begin
    logic saw;
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_resp",  32'({resp_valid, resp_fault, dmem_read, dmem_write}), 32'h0);
    chk("rst_rdata", resp_data, 32'h0);
    chk("rst_addr",  dmem_address, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    preload(2, 32'hDEAD_BEEF);
    issue("lw_w2", 3'd2, 32'h1000_0008, 32'h0);
    chk("lw_w2_const", resp_data, 32'hDEAD_BEEF);

    preload(2, 32'h80FF_1234);
    issue("lb",  3'd0, 32'h1000_000B, 32'h0);
    chk("lb_const", resp_data, 32'hFFFF_FF80);
    issue("lbu", 3'd3, 32'h1000_000B, 32'h0);
    chk("lbu_const", resp_data, 32'h0000_0080);
    issue("lhu", 3'd4, 32'h1000_000A, 32'h0);
    chk("lhu_const", resp_data, 32'h0000_80FF);
    issue("lh",  3'd1, 32'h1000_000A, 32'h0);
    issue("lb0", 3'd0, 32'h1000_0008, 32'h0);

    preload(1, 32'h1122_3344);
    issue("sb", 3'd5, 32'h1000_0005, 32'h0000_00AB);
    chk("sb_mem", mem[1], 32'h1122_AB44);

    issue("flt_lw",  3'd2, 32'h1000_0002, 32'h0);
    issue("flt_sw",  3'd7, 32'h1000_0080, 32'h1234_5678);
    issue("flt_lo",  3'd0, 32'h0FFF_FFFF, 32'h0);
    issue("flt_lh",  3'd1, 32'h1000_007F, 32'h0);
    issue("flt_top", 3'd3, 32'h9000_0000, 32'h0);
    issue("lbu_end", 3'd3, 32'h1000_007F, 32'h0);

    issue("sw_end", 3'd7, 32'h1000_007C, 32'h5A5A_5A5A);
    issue("lw_end", 3'd2, 32'h1000_007C, 32'h0);
    chk("lw_end_const", resp_data, 32'h5A5A_5A5A);

    preload(3, 32'h0102_0304);
    issue("sh_hi", 3'd6, 32'h1000_000E, 32'h0000_BEEF);
    chk("sh_hi_mem", mem[3], 32'hBEEF_0304);
    issue("lh_hi", 3'd1, 32'h1000_000E, 32'h0);

    // Reset while an SH is in its write cycle: the write must not land.
    begin
      int guard;
      guard = 0;
      while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      req_op = 3'd6; req_addr = 32'h1000_0004; req_wdata = 32'h0000_CAFE; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      guard = 0;
      while (!dmem_write && guard < 20) begin @(posedge clk); #1; guard++; end
      chk("rst_sh_wr", 32'(dmem_write), 32'h1);
      reset = 1'b1;
      #1;
      chk("rst_mid_wr",    32'(dmem_write), 32'h0);
      chk("rst_mid_ready", 32'(req_ready), 32'h1);
      chk("rst_mid_resp",  32'(resp_valid), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      saw = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        if (resp_valid) saw = 1'b1;
      end
      chk("rst_no_resp", 32'(saw), 32'h0);
      chk("rst_mem",     mem[1], ref_mem[1]);
    end
    issue("lw_after_rst", 3'd2, 32'h1000_0004, 32'h0);
    chk("lw_after_rst_const", resp_data, 32'h1122_AB44);

    chk("sbq_empty", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store controller that sits directly upstream of the data memory (DMEM, word-only, 32 words at 0x10000000–0x1000007C).
- Accepts one memory request from the EX/MEM stage and performs range and alignment checks.
- Handles byte, halfword and word accesses: sub-word stores use a read-modify-write on the DMEM word; loads are lane-extracted and sign- or zero-extended.
- Raises a one-cycle response to the pipeline, which stalls while req_ready is low.

Parameters:
- READ_WAIT, 2: cycles dmem_read and dmem_address are held before dmem_rdata is sampled; must be ≥1 and must cover the DMEM read delay.
- BASE_ADDR, 32'h10000000: first valid data address.
- NUM_WORDS, 32: modelled words; last valid word address is BASE_ADDR + 4*(NUM_WORDS-1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept a request.
- req_op  input  3  operation code (see package).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the sub-word is taken from the low bits.
- resp_valid  output  1  one-cycle completion pulse.
- resp_data  output  32  extended load data; 0 for stores and faults.
- resp_fault  output  1  access was misaligned or out of range; no memory effect.
- dmem_address  output  32  word-aligned address to DMEM.
- dmem_read  output  1  DMEM read control.
- dmem_write  output  1  DMEM write control.
- dmem_wdata  output  32  DMEM write data.
- dmem_rdata  input  32  DMEM read data.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; req_ready=1; every other output is 0, including dmem_address.
- Reset mid-operation: dmem_write and dmem_read drop immediately and no response is issued. A write already committed at a prior edge stands.
- States: IDLE, RD_WAIT, WR, RESP.
- Handshake: req_ready=1 only in IDLE. A request is accepted on a rising edge where req_valid & req_ready; op, addr and wdata are latched.
- Fault check at acceptance:
  - Out of range: addr < BASE_ADDR, addr > last word address + 3, or addr[31]=1.
  - Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - On a fault: go to RESP with resp_fault=1, resp_data=0, and no dmem_read or dmem_write assertion.
- Loads: IDLE→RD_WAIT. dmem_read=1 and dmem_address={addr[31:2],2'b00} are held for READ_WAIT cycles. At the edge ending the last wait cycle, dmem_rdata is captured, lane-extracted and extended, then →RESP.
- SW: IDLE→WR. dmem_write=1 and dmem_wdata=wdata for exactly one cycle; the edge ending WR commits the write. Then →RESP.
- SB/SH: RD_WAIT as for a load. The captured word is merged with the new byte/half in the selected lane; WR writes the merged word; then →RESP.
- Lanes are little-endian: byte n occupies bits 8n+7:8n; the half at addr[1]=1 occupies 31:16.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through unchanged.
- RESP lasts one cycle: resp_valid=1, resp_data and resp_fault valid, then →IDLE.
- resp_data and resp_fault hold their values until the next RESP. resp_valid is 0 outside RESP.
- A new request can be accepted at the edge ending RESP+1, i.e. back-to-back issue costs one IDLE cycle.
- Latency, with acceptance at edge N:
  - Load: resp_valid in cycle N+READ_WAIT+1.
  - SW: resp_valid in cycle N+2.
  - SB/SH: resp_valid in cycle N+READ_WAIT+2.
  - Fault: resp_valid in cycle N+1.
- dmem_read and dmem_write are never high in the same cycle.
- All outputs are registered or decoded from the state register; there are no combinational paths from req_* to dmem_*.

Decomposition:
- Shared package mips_mem_pkg:
  - Op codes: LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7.
  - State encoding: IDLE=0, RD_WAIT=1, WR=2, RESP=3.
  - DATA_BASE=32'h10000000.
- One combinational sub-module, mem_lane_align: given op, addr[1:0], read word and store data, it produces the extended load value and the merged store word. Reused by any future cache stage.

Test Plan:
- LW at 0x10000008 with DMEM word 2=0xDEADBEEF → resp_valid at N+3 (READ_WAIT=2), resp_data=0xDEADBEEF, resp_fault=0.
- LB at 0x1000000B with word 2=0x80FF1234 → resp_data=0xFFFFFF80; LBU at the same address → 0x00000080; LHU at 0x1000000A → 0x000080FF.
- SB data 0xAB at 0x10000005 with word 1=0x11223344 → a single dmem_write pulse writes 0x1122AB44; resp_valid at N+4.
- LW at 0x10000002 and SW at 0x10000080 → resp_fault=1, resp_data=0, no dmem_read or dmem_write pulse, resp_valid at N+1.
- SW 0x5A5A5A5A to 0x1000007C, then LW from the same address issued the cycle after resp_valid → returns 0x5A5A5A5A; req_ready=0 throughout both operations until IDLE.
- Assert reset during the WR cycle of an SH → dmem_write drops immediately, req_ready=1, resp_valid stays 0; the following LW completes normally.
